// File: rtl/psg_write_encoder_if.sv
// Request and chip-side write bus of the SN76489 command encoder.
// The master modport is the host/chip side; the slave modport is the encoder.
interface psg_write_encoder_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_channel;
  logic       req_is_volume;
  logic [9:0] req_value;
  logic [7:0] bus_data;
  logic       bus_we_n;
  logic       chip_ready;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req_valid, req_channel, req_is_volume, req_value, chip_ready,
    input  req_ready, bus_data, bus_we_n, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_channel, req_is_volume, req_value, chip_ready,
    output req_ready, bus_data, bus_we_n, busy, timeout_err
  );
endinterface

// File: rtl/psg_write_encoder.sv
// Serialises one SN76489 register update into latch/data bytes with an
// active-low WE strobe, honouring chip READY and a bounded strobe length.
module psg_write_encoder #(
  parameter int MIN_WE  = 2,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 reset,
  psg_write_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_WE - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  function automatic logic [7:0] latch_byte(input logic [1:0] ch, input logic ty,
                                            input logic [3:0] d);
    return {1'b1, ch, ty, d};
  endfunction

  function automatic logic [7:0] data_byte(input logic [9:0] value);
    return {2'b00, value[9:4]};
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    bus_data_q, bus_data_d;
  logic          bus_we_n_q, bus_we_n_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic          sh_valid_q, sh_valid_d;
  logic [2:0]    last_reg_q, last_reg_d;
  logic [3:0]    last_lo_q, last_lo_d;

  logic          accept_s, ok_s, to_end_s, to_hit_s;
  logic          is_tone_s, is_noise_s, shortcut_s;
  logic [3:0]    nibble_s;
  logic [7:0]    latch_byte_s, data_byte_s;

  // Request decode, strobe completion conditions and the tone shortcut test.
  always_comb begin
    accept_s     = (state_q == IDLE) & bus.req_valid;
    ok_s         = (state_q == STROBE) & (cnt_q >= MIN_LAST) & bus.chip_ready;
    to_end_s     = (state_q == STROBE) & (cnt_q == TO_LAST);
    // A ready completion on the last allowed cycle is not a timeout.
    to_hit_s     = to_end_s & ~ok_s;
    is_noise_s   = ~bus.req_is_volume & (bus.req_channel == 2'd3);
    is_tone_s    = ~bus.req_is_volume & (bus.req_channel != 2'd3);
    nibble_s     = is_noise_s ? {1'b0, bus.req_value[2:0]} : bus.req_value[3:0];
    latch_byte_s = latch_byte(bus.req_channel, bus.req_is_volume, nibble_s);
    data_byte_s  = data_byte(bus.req_value);
    shortcut_s   = is_tone_s & sh_valid_q & (last_reg_q == {bus.req_channel, 1'b0}) &
                   (last_lo_q == bus.req_value[3:0]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = STROBE;
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        if (ok_s | to_end_s) begin
          state_d = RECOVER;
        end else begin
          state_d = STROBE;
        end
      end
      RECOVER: begin
        if (pend_q) begin
          state_d = STROBE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath, shadow and registered output values for the next cycle.
  always_comb begin
    cnt_d         = cnt_q;
    bus_data_d    = bus_data_q;
    pend_d        = pend_q;
    pend_data_d   = pend_data_q;
    sh_valid_d    = sh_valid_q;
    last_reg_d    = last_reg_q;
    last_lo_d     = last_lo_q;
    timeout_err_d = timeout_err_q | to_hit_s;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (accept_s) begin
          bus_data_d  = shortcut_s ? data_byte_s : latch_byte_s;
          pend_d      = is_tone_s & ~shortcut_s;
          pend_data_d = data_byte_s;
          if (!shortcut_s) begin
            sh_valid_d = 1'b1;
            last_reg_d = {bus.req_channel, bus.req_is_volume};
            last_lo_d  = nibble_s;
          end else begin
            sh_valid_d = sh_valid_q;
          end
        end else begin
          pend_d = 1'b0;
        end
      end
      STROBE: begin
        cnt_d = cnt_q + CW'(1);
      end
      RECOVER: begin
        cnt_d  = {CW{1'b0}};
        pend_d = 1'b0;
        if (pend_q) begin
          bus_data_d = pend_data_q;
        end else begin
          bus_data_d = bus_data_q;
        end
      end
      default: cnt_d = {CW{1'b0}};
    endcase
    bus_we_n_d  = (state_d != STROBE);
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= {CW{1'b0}};
      bus_data_q    <= 8'h00;
      bus_we_n_q    <= 1'b1;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_data_q   <= 8'h00;
      sh_valid_q    <= 1'b0;
      last_reg_q    <= 3'd0;
      last_lo_q     <= 4'd0;
    end else begin
      cnt_q         <= cnt_d;
      bus_data_q    <= bus_data_d;
      bus_we_n_q    <= bus_we_n_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      pend_q        <= pend_d;
      pend_data_q   <= pend_data_d;
      sh_valid_q    <= sh_valid_d;
      last_reg_q    <= last_reg_d;
      last_lo_q     <= last_lo_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.bus_data    = bus_data_q;
  assign bus.bus_we_n    = bus_we_n_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/psg_write_encoder.md
# psg_write_encoder

Host-side command encoder for the SN76489 register interface. It accepts one register update per request (tone period, attenuation or noise control for channels 0–3) and serialises it into the chip's latch/data byte format. It drives the 8-bit write bus with an active-low WE strobe and honours the chip's READY handshake. It sits between the host/bus bridge and the PSG core, or an external SN76489 pin interface, and is the transmitter for the core's register-write decoder.

## Interface

- MIN_WE, default 2: minimum number of cycles WE is held low per byte (≥1).
- TIMEOUT, default 64: maximum number of cycles WE is held low waiting for chip_ready before the write is forced to end.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  encoder idle; a request is accepted when req_valid & req_ready.
- req_channel  in  2  channel number: 0–2 tone, 3 noise.
- req_is_volume  in  1  1 = attenuation register, 0 = tone period or noise control.
- req_value  in  10  payload:
  - tone: 10-bit period.
  - volume: [3:0].
  - noise control: [2:0] = {FB, NF1, NF0}.
- bus_data  out  8  byte presented to the chip.
- bus_we_n  out  1  active-low write strobe.
- chip_ready  in  1  high when the chip can complete a write.
- busy  out  1  high while any byte of the current request is in flight.
- timeout_err  out  1  sticky flag, set when any byte hits TIMEOUT; cleared only by reset.

## Operation

- Byte formats:
  - Latch byte: {1, ch[1:0], type, d[3:0]}.
  - Data byte: {0, 0, value[9:4]}.
- Per request type:
  - Tone (ch 0–2, req_is_volume = 0): type = 0, d = value[3:0]; the data byte follows the latch byte.
  - Volume (any ch): type = 1, d = value[3:0]; single byte.
  - Noise control (ch 3, req_is_volume = 0): type = 0, d = {0, value[2:0]}; single byte. It is always sent, because every write reseeds the LFSR.
- Shadow state: last_reg (3 bits {ch, type}), last_lo (4 bits), and a valid bit. All are updated whenever a latch byte is sent.
- Tone shortcut: if shadow valid, last_reg == {ch, 0} and last_lo == value[3:0], only the data byte is sent.
- Request fields are captured at acceptance. Later changes on req_* are ignored until req_ready returns high.
- FSM states: IDLE, STROBE, RECOVER.
  - IDLE: req_ready = 1, busy = 0, bus_we_n = 1. On acceptance, load the first byte into bus_data, go to STROBE, clear the cycle counter.
  - STROBE: bus_we_n = 0, counter increments.
    - Exit to RECOVER when counter ≥ MIN_WE-1 and chip_ready = 1.
    - Also exit to RECOVER when counter == TIMEOUT-1; set timeout_err.
  - RECOVER: one cycle with bus_we_n = 1. If a second byte is pending, load it and go to STROBE. Otherwise go to IDLE.
- bus_data is stable throughout STROBE and RECOVER, and holds its last value in IDLE.
- Simultaneous chip_ready and timeout in the same cycle: treat as a normal completion, timeout_err not set.
- Reset mid-operation: next edge forces IDLE, bus_we_n = 1, shadow invalid. No partial byte is resumed.

## Timing

- Reset values:
  - req_ready = 1, busy = 0, bus_we_n = 1, bus_data = 8'h00, timeout_err = 0.
  - State IDLE, shadow invalid.
- Tone request accepted at edge 0, MIN_WE = 2, chip_ready held high:
  - Latch byte with we_n low in cycles 1–2.
  - RECOVER in cycle 3.
  - Data byte with we_n low in cycles 4–5.
  - RECOVER in cycle 6.
  - req_ready = 1 in cycle 7.
- Single-byte request: req_ready is high again 4 cycles after acceptance.
- Each cycle that chip_ready is low after the minimum extends STROBE by one cycle.
- Back-to-back: a request may be accepted in the first IDLE cycle; there are no extra bubbles.

## Test plan

- After reset, tone ch1 value 10'h2A5 → bytes 8'hA5 then 8'h2A, each we_n low 2 cycles; busy low at cycle 7.
- Same ch1 tone again with value 10'h3F5 (low nibble 5 unchanged) → only data byte 8'h3F sent. Then ch1 value 10'h3F6 → 8'hA6, 8'h3F.
- Volume ch2 value 4'h7 → single byte 8'hD7. A following tone ch2 value 10'h007 still sends both bytes (last latch was the volume register).
- Noise control 3'b101, sent twice → 8'hE5 written both times; shadow does not suppress it.
- chip_ready held low 10 cycles into STROBE → we_n low 11 cycles, then normal completion. Held low permanently → we_n released after 64 cycles, timeout_err = 1 and stays set.
- Reset asserted in the second STROBE of a tone write → next cycle bus_we_n = 1, req_ready = 1. The next tone to the same register sends both bytes.
